// File: rtl/cpu_controller.sv
// Control FSM for the register-file/ALU datapath: owns PC and IR, fetches
// 16-bit instructions and drives register-file, ALU and data-memory controls.
//
// state  | meaning
// INIT   | post-reset idle, one cycle before the first fetch
// FETCH  | IR <= IM_data, PC <= PC + 1
// DECODE | select execute state from opcode
// NOOP   | no operation (also any unknown opcode)
// STORE  | D[IR[7:0]] <= RF[rA]
// LOAD_A | synchronous data-memory read cycle
// LOAD_B | RF[rQ] <= data-memory read data
// ADD    | RF[rQ] <= RF[rA] + RF[rB]
// SUB    | RF[rQ] <= RF[rA] - RF[rB]
// HALT   | parked until reset
module cpu_controller #(
    parameter int         PC_WIDTH = 7,
    parameter logic [3:0] HALT_OP  = 4'b0101
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         IM_data,
    output logic [PC_WIDTH-1:0] PC_addr,
    output logic [7:0]          D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [4:0]          RF_W_addr,
    output logic [4:0]          RF_Ra_addr,
    output logic [4:0]          RF_Rb_addr,
    output logic [2:0]          ALU_s0,
    output logic                halted,
    output logic [3:0]          state_out
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_LOAD_A = 4'd5;
    localparam logic [3:0] S_LOAD_B = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;

    logic [3:0]          state;
    logic [3:0]          next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;

    logic [3:0] opcode;
    logic [4:0] r_a;
    logic [4:0] r_b;
    logic [4:0] r_q;

    assign opcode = ir[15:12];
    assign r_a    = {1'b0, ir[11:8]};
    assign r_b    = {1'b0, ir[7:4]};
    assign r_q    = {1'b0, ir[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH) begin
                ir <= IM_data;
                pc <= pc + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    next_state = S_HALT;
                end else begin
                    case (opcode)
                        4'b0001: next_state = S_STORE;
                        4'b0010: next_state = S_LOAD_A;
                        4'b0011: next_state = S_ADD;
                        4'b0100: next_state = S_SUB;
                        default: next_state = S_NOOP;
                    endcase
                end
            end
            S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: next_state = S_FETCH;
            S_LOAD_A: next_state = S_LOAD_B;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    // Moore decode; reset forces INIT and IR = 0, so every strobe drops at once.
    always_comb begin
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = '0;
        halted     = 1'b0;
        case (state)
            S_STORE: begin
                D_addr     = ir[7:0];
                RF_Ra_addr = r_a;
                D_wr       = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = r_q;
                RF_W_en   = (state == S_LOAD_B);
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = r_a;
                RF_Rb_addr = r_b;
                RF_W_addr  = r_q;
                ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                RF_W_en    = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign PC_addr   = pc;
    assign state_out = state;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed programs plus randomized instruction
// streams, checked cycle by cycle against an instruction-level model.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] IM_data;
    logic [6:0]  PC_addr;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [4:0]  RF_W_addr;
    logic [4:0]  RF_Ra_addr;
    logic [4:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic        halted;
    logic [3:0]  state_out;

    logic [15:0] mem [128];
    int checks = 0;
    int errors = 0;

    assign IM_data = mem[PC_addr];

    cpu_controller dut (
        .clk        (clk),
        .reset      (reset),
        .IM_data    (IM_data),
        .PC_addr    (PC_addr),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_en    (RF_W_en),
        .RF_W_addr  (RF_W_addr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .halted     (halted),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] observed();
        return {27'd0, PC_addr, D_addr, D_wr, RF_s, RF_W_en, RF_W_addr,
                RF_Ra_addr, RF_Rb_addr, ALU_s0, halted};
    endfunction

    // Expected outputs for instruction w. phase 0 = fetch, 1 = decode,
    // 2 = first execute cycle, 3 = second execute cycle (LOAD only).
    function automatic logic [63:0] model(input logic [15:0] w, input logic [6:0] pa,
                                          input int phase);
        logic [7:0] da = '0;
        logic       dwr = 0, rfs = 0, wen = 0, hlt = 0;
        logic [4:0] wa = '0, ra = '0, rb = '0;
        logic [2:0] alu = '0;
        if (phase >= 2) begin
            case (w[15:12])
                4'd1: begin da = w[7:0]; ra = {1'b0, w[11:8]}; dwr = 1; end
                4'd2: begin da = w[11:4]; rfs = 1; wa = {1'b0, w[3:0]}; wen = (phase == 3); end
                4'd3, 4'd4: begin
                    ra = {1'b0, w[11:8]}; rb = {1'b0, w[7:4]}; wa = {1'b0, w[3:0]};
                    alu = (w[15:12] == 4'd3) ? 3'd1 : 3'd2; wen = 1;
                end
                4'd5: hlt = 1;
                default: ;
            endcase
        end
        return {27'd0, pa, da, dwr, rfs, wen, wa, ra, rb, alu, hlt};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge while the DUT is in FETCH; returns at the next FETCH.
    task automatic run_instr(input logic [6:0] pc);
        logic [15:0] w = mem[pc];
        int n_exec = (w[15:12] == 4'd2) ? 2 : 1;
        check($sformatf("fetch pc=%0d", pc), observed(), model(w, pc, 0));
        @(negedge clk);
        check($sformatf("decode pc=%0d w=%h", pc, w), observed(), model(w, pc + 7'd1, 1));
        for (int k = 0; k < n_exec; k++) begin
            @(negedge clk);
            check($sformatf("exec%0d pc=%0d w=%h", k, pc, w), observed(), model(w, pc + 7'd1, 2 + k));
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " outputs"}, observed(), 64'd0);
        check({tag, " state"}, {60'd0, state_out}, 64'd0);
    endtask

    function automatic logic [15:0] rand_word();
        int op = $urandom_range(0, 14);
        logic [11:0] f = 12'($urandom);
        if (op >= 5) op++;
        return {op[3:0], f};
    endfunction

    initial begin
        logic [6:0] pc;

        // Program: ADD, LOAD, STORE, then random non-HALT words across the whole memory.
        mem[0] = 16'h3123;
        mem[1] = 16'h21B5;
        mem[2] = 16'h15A7;
        for (int i = 3; i < 128; i++) mem[i] = rand_word();

        #2 reset = 1'b1;
        #1 check_reset_state("reset");
        @(negedge clk);
        check_reset_state("reset held");
        reset = 1'b0;
        @(negedge clk);

        pc = 7'd0;
        for (int i = 0; i < 140; i++) begin
            run_instr(pc);
            pc = pc + 7'd1;
        end

        // Reset asserted in the middle of LOAD_A.
        reset = 1'b1;
        #1 mem[0] = 16'h2ABC;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("load fetch", observed(), model(mem[0], 7'd0, 0));
        @(negedge clk);
        check("load decode", observed(), model(mem[0], 7'd1, 1));
        @(negedge clk);
        check("load_a", observed(), model(mem[0], 7'd1, 2));
        reset = 1'b1;
        #1 check_reset_state("mid-load reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_state("mid-load held");
        end
        reset = 1'b0;
        @(negedge clk);
        run_instr(7'd0);

        // SUB, illegal opcode, HALT.
        reset = 1'b1;
        #1;
        mem[0] = 16'h4456;
        mem[1] = 16'hF000;
        mem[2] = 16'h5000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_instr(7'd0);
        run_instr(7'd1);
        check("halt fetch", observed(), model(mem[2], 7'd2, 0));
        @(negedge clk);
        check("halt decode", observed(), model(mem[2], 7'd3, 1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("halt cycle %0d", i), observed(), model(mem[2], 7'd3, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control unit (FSM) that drives the register-file/ALU datapath.
- Owns the program counter (PC) and instruction register (IR). Fetches 16-bit instructions from instruction memory and decodes them.
- Sequences register-file read/write addresses, write enable, ALU select, write-data mux select, and data-memory address/write strobes.
- Sits between instruction memory and the datapath; the datapath consumes every control output of this block.

Parameters:
- PC_WIDTH, 7, instruction-memory address width; PC wraps modulo 2^PC_WIDTH.
- HALT_OP, 4'b0101, opcode that parks the FSM in HALT.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- IM_data  input  16  instruction word at PC_addr (combinational read).
- PC_addr  output  PC_WIDTH  instruction-memory address = current PC.
- D_addr  output  8  data-memory address.
- D_wr  output  1  data-memory write strobe.
- RF_s  output  1  RF write-data mux: 0 = ALU Q, 1 = data-memory read data.
- RF_W_en  output  1  register-file write enable.
- RF_W_addr  output  5  register-file write address.
- RF_Ra_addr  output  5  read address A.
- RF_Rb_addr  output  5  read address B.
- ALU_s0  output  3  ALU select: 000 pass A, 001 A+B, 010 A-B.
- halted  output  1  high while in HALT.
- state_out  output  4  current state encoding, for debug.

Behaviour:
- Reset is asynchronous and active-high.
  - State = INIT, PC = 0, IR = 0.
  - All outputs are 0 immediately, including any write strobe mid-instruction.
  - While reset is asserted, nothing advances.
- Instruction fields:
  - opcode = IR[15:12].
  - Register fields are zero-extended to 5 bits: rA = {0,IR[11:8]}, rB = {0,IR[7:4]}, rQ = {0,IR[3:0]}.
- Opcodes:
  - 0000 NOOP.
  - 0001 STORE: D[IR[7:0]] <= RF[rA].
  - 0010 LOAD: RF[rQ] <= D[IR[11:4]].
  - 0011 ADD: RF[rQ] <= RF[rA] + RF[rB].
  - 0100 SUB: RF[rQ] <= RF[rA] - RF[rB].
  - 0101 HALT.
  - Any other opcode executes as NOOP.
- States and transitions:
  - INIT -> FETCH.
  - FETCH: IR <= IM_data, PC <= PC+1; -> DECODE.
  - DECODE: -> NOOP / STORE / LOAD_A / ADD / SUB / HALT by opcode.
  - NOOP, STORE, LOAD_B, ADD, SUB -> FETCH.
  - LOAD_A -> LOAD_B.
  - HALT -> HALT; only reset exits.
- Outputs are Moore, decoded from state and IR. Any output not listed for a state is 0.
  - STORE: D_addr = IR[7:0], RF_Ra_addr = rA, D_wr = 1.
  - LOAD_A: D_addr = IR[11:4], RF_s = 1, RF_W_addr = rQ, RF_W_en = 0. This is the synchronous data-memory read cycle.
  - LOAD_B: same as LOAD_A, but RF_W_en = 1.
  - ADD: RF_Ra_addr = rA, RF_Rb_addr = rB, RF_W_addr = rQ, ALU_s0 = 001, RF_s = 0, RF_W_en = 1.
  - SUB: same as ADD, but ALU_s0 = 010.
  - HALT: halted = 1.
- Latency from FETCH to next FETCH: 3 cycles for NOOP/STORE/ADD/SUB, 4 cycles for LOAD.
- The first FETCH occurs 1 cycle after reset is released.
- PC increments only in FETCH. PC wraps from 2^PC_WIDTH-1 to 0 with no flag.
- At most one of RF_W_en and D_wr is high in any cycle. Each strobe is high for exactly one cycle per instruction.
- If rQ equals rA or rB, the write lands at the clock edge ending the execute state. Reads in that state see the old value.

Test Plan:
- Reset and first fetch:
  - Stimulus: assert reset mid-cycle, IM_data = 16'h0000.
  - Required: all outputs are 0 asynchronously, state_out = INIT, PC_addr = 0.
  - After release: FETCH, then PC_addr = 1 after the next edge.
- ADD:
  - Stimulus: IM word at PC 0 = 16'h3123.
  - Required, in the ADD cycle: RF_Ra_addr = 1, RF_Rb_addr = 2, RF_W_addr = 3, ALU_s0 = 001, RF_W_en = 1 for exactly one cycle.
  - Next state is FETCH with PC_addr = 1.
- LOAD then STORE:
  - Stimulus: 16'h2 1B 5 (= 16'h21B5), then 16'h15A7.
  - Required for LOAD: D_addr = 8'h1B and RF_s = 1 in both LOAD_A and LOAD_B; RF_W_en = 1 only in LOAD_B, with RF_W_addr = 5.
  - Required for STORE: D_addr = 8'hA7, RF_Ra_addr = 5, D_wr = 1 for one cycle.
- SUB, illegal opcode, and HALT:
  - Stimulus: sequence 16'h4456, 16'hF000, 16'h5000.
  - Required: SUB cycle shows ALU_s0 = 010. 16'hF000 behaves as NOOP with no strobes.
  - HALT: halted = 1 held for 20 cycles, PC_addr frozen at 3.
- PC wrap:
  - Stimulus: 128 NOOP words.
  - Required: PC_addr goes 127 -> 0 on the 128th FETCH, and execution continues.
- Reset mid-LOAD:
  - Stimulus: assert reset in LOAD_A.
  - Required: RF_W_en never asserts, state = INIT, PC = 0.
  - Fetch restarts at address 0 after release.
